// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer: streams a two-line, 32-character message to an LCD controller.
// Build option LCD_MSG_WRITER_CLEAR_EN prepends a clear-display command (0x001).
module lcd_msg_writer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       load_we,
  input  logic [4:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       active,
  output logic       done
);

`ifdef LCD_MSG_WRITER_CLEAR_EN
  localparam logic [5:0] OFS = 6'd1;
`else
  localparam logic [5:0] OFS = 6'd0;
`endif
  localparam logic [5:0] LAST = 6'd33 + OFS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_buf [32];
  logic [5:0] r_idx;
  logic [5:0] w_idx_next;
  logic [5:0] w_pos;
  logic [9:0] w_xfer;
  logic       w_done;
  logic       r_enable;
  logic [9:0] r_bus;
  logic       r_active;
  logic       r_done;

  assign lcd_enable = r_enable;
  assign lcd_bus    = r_bus;
  assign active     = r_active;
  assign done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (load_we && !r_active) begin
      r_buf[load_addr] <= load_data;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = WAIT_RDY;
          w_idx_next = '0;
        end
      end
      WAIT_RDY: if (!lcd_busy) w_next = ISSUE;
      ISSUE:    w_next = WAIT_ACK;
      WAIT_ACK: if (lcd_busy) w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!lcd_busy) begin
          if (r_idx == LAST) begin
            w_next = IDLE;
            w_done = 1'b1;
          end else begin
            w_next     = ISSUE;
            w_idx_next = r_idx + 6'd1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Position within the 34-entry line sequence, after any clear command.
  always_comb begin
    w_pos  = w_idx_next - OFS;
    w_xfer = 10'h000;
    if (OFS != 6'd0 && w_idx_next == 6'd0)
      w_xfer = 10'h001;
    else if (w_pos == 6'd0)
      w_xfer = 10'h080;
    else if (w_pos == 6'd17)
      w_xfer = 10'h0C0;
    else if (w_pos < 6'd17)
      w_xfer = {2'b10, r_buf[w_pos[4:0] - 5'd1]};
    else
      w_xfer = {2'b10, r_buf[w_pos[4:0] - 5'd2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_enable <= 1'b0;
      r_bus    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_idx    <= w_idx_next;
      r_enable <= (w_next == ISSUE);
      r_bus    <= (w_next == IDLE) ? 10'h000 : w_xfer;
      r_active <= (w_next != IDLE);
      r_done   <= w_done;
    end
  end

endmodule
